// File: rtl/scope_pkg.sv
// scope_pkg: shared state encoding, sample width and default geometry for the scope capture path.
package scope_pkg;
  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;
  localparam int SAMPLE_W = 8;
  localparam int ADDR_W_DEF = 10;
  localparam int PRE_TRIG_DEF = 512;
  localparam int AUTO_TO_DEF = 4096;
endpackage

// File: rtl/scope_trig_detect.sv
// scope_trig_detect: level crossing compare between the previous and current decimated samples.
module scope_trig_detect
  import scope_pkg::*;
(
  input  logic [SAMPLE_W-1:0] adc_prev,
  input  logic [SAMPLE_W-1:0] adc_q,
  input  logic [SAMPLE_W-1:0] level,
  input  logic                trig_edge,
  output logic                hit
);
  assign hit = trig_edge ? (adc_prev > level && adc_q <= level)
                         : (adc_prev < level && adc_q >= level);
endmodule

// File: rtl/scope_capture_ctrl.sv
// scope_capture_ctrl: decimates ADC samples into a circular RAM and freezes a pre/post-trigger frame.
module scope_capture_ctrl
  import scope_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PRE_TRIG = PRE_TRIG_DEF,
  parameter int AUTO_TO  = AUTO_TO_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                cont_mode,
  input  logic                auto_mode,
  input  logic                trig_edge,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic [7:0]          decim,
  input  logic [SAMPLE_W-1:0] adc_din,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                frame_valid,
  output logic [ADDR_W-1:0]   frame_base,
  input  logic                frame_ack,
  output logic                trig_forced,
  output logic                busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int POST_N = DEPTH - PRE_TRIG;
  state_t state, state_n;
  logic [7:0] dcnt, decim_q;
  logic [SAMPLE_W-1:0] adc_q, adc_prev;
  logic [31:0] cnt, cnt_n;
  logic [ADDR_W-1:0] base_n;
  logic hit, run, strobe, forced_n;
  scope_trig_detect u_trig (
    .adc_prev (adc_prev),
    .adc_q    (adc_q),
    .level    (trig_level),
    .trig_edge(trig_edge),
    .hit      (hit)
  );
  assign run = state inside {PRE, ARMED, POST};
  assign strobe = run && dcnt == decim_q;
  assign wr_data = adc_q;
  assign frame_valid = state == DONE;
  assign busy = state != IDLE;
  // Trigger and count decisions are taken only on RAM write cycles.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    forced_n = trig_forced;
    base_n = frame_base;
    if (abort) state_n = IDLE;
    else case (state)
      IDLE: if (start) begin
        state_n = PRE;
        cnt_n = '0;
        forced_n = 1'b0;
      end
      PRE: if (wr_en) begin
        cnt_n = cnt == 32'(PRE_TRIG - 1) ? '0 : cnt + 1;
        state_n = cnt == 32'(PRE_TRIG - 1) ? ARMED : PRE;
      end
      ARMED: if (wr_en) begin
        cnt_n = cnt + 1;
        if (hit || (auto_mode && cnt == 32'(AUTO_TO - 1))) begin
          state_n = POST_N == 1 ? DONE : POST;
          cnt_n = 32'd1;
          forced_n = !hit;
          base_n = wr_addr - ADDR_W'(PRE_TRIG);
        end
      end
      POST: if (wr_en) begin
        cnt_n = cnt + 1;
        state_n = cnt == 32'(POST_N - 1) ? DONE : POST;
      end
      DONE: if (frame_ack) begin
        state_n = cont_mode ? PRE : IDLE;
        cnt_n = '0;
        forced_n = cont_mode ? 1'b0 : trig_forced;
      end
      default: state_n = IDLE;
    endcase
  end
  // decim is latched at each wrap so a mid-count change cannot skip past the compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dcnt <= '0;
      decim_q <= '0;
      adc_q <= '0;
      adc_prev <= '0;
      cnt <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      frame_base <= '0;
      trig_forced <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      trig_forced <= forced_n;
      frame_base <= base_n;
      dcnt <= (!run || strobe) ? '0 : dcnt + 8'd1;
      decim_q <= (!run || strobe) ? decim : decim_q;
      adc_q <= strobe ? adc_din : adc_q;
      adc_prev <= strobe ? adc_q : adc_prev;
      wr_en <= strobe && state_n inside {PRE, ARMED, POST};
      wr_addr <= wr_addr + ADDR_W'(wr_en);
    end
  end
endmodule

// File: tb/tb_scope_capture_ctrl.sv
// tb_scope_capture_ctrl: randomized scoreboard bench with a sample-stream reference model.
module tb_scope_capture_ctrl;
  localparam int AW = 6, DEPTH = 64, PT = 20, AT = 16, POSTN = DEPTH - PT, LEN = 1024;
  typedef struct {int addr; int data; int cyc;} wr_t;
  typedef struct {int base; int forced;} fr_t;
  logic clk = 0, rst = 1, start = 0, abort = 0, cont_mode = 0, auto_mode = 0, trig_edge = 0;
  logic [7:0] trig_level = 128, decim = 0, adc_din = 0;
  logic frame_ack = 0;
  logic wr_en, frame_valid, trig_forced, busy;
  logic [AW-1:0] wr_addr, frame_base;
  logic [7:0] wr_data;
  wr_t wq[$];
  fr_t fq[$];
  wr_t w;
  fr_t f;
  int checks = 0, errors = 0, tick = 0, cyc = 0, t0 = 0, m_addr = 0;
  int stream[LEN];
  logic fv_d = 0;

  scope_capture_ctrl #(.ADDR_W(AW), .PRE_TRIG(PT), .AUTO_TO(AT)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont_mode(cont_mode),
    .auto_mode(auto_mode), .trig_edge(trig_edge), .trig_level(trig_level), .decim(decim),
    .adc_din(adc_din), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_valid(frame_valid), .frame_base(frame_base), .frame_ack(frame_ack),
    .trig_forced(trig_forced), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tick <= tick + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (wq.size() == 0) chk("unexpected_wr_en", wr_en, 0);
        else begin
          w = wq.pop_front();
          chk("wr_addr", wr_addr, w.addr);
          chk("wr_data", wr_data, w.data);
          chk("wr_cycle", tick, w.cyc);
        end
      end
      if (frame_valid && !fv_d) begin
        if (fq.size() == 0) chk("unexpected_frame", frame_valid, 0);
        else begin
          f = fq.pop_front();
          chk("frame_base", frame_base, f.base);
          chk("trig_forced", trig_forced, f.forced);
          chk("writes_outstanding", wq.size(), 0);
        end
      end
    end
    fv_d <= frame_valid && !rst;
  end

  function automatic int samp(int dec, int k);
    int i = dec + k * (dec + 1);
    return i < LEN ? stream[i] : -1;
  endfunction

  function automatic int wcyc(int dec, int k);
    return dec + k * (dec + 1) + 1;
  endfunction

  function automatic int find_t(int dec, int lvl, bit fall, bit am, output int forced);
    forced = 0;
    for (int k = PT; samp(dec, k) >= 0; k++) begin
      int p = samp(dec, k - 1), q = samp(dec, k);
      if (fall ? (p > lvl && q <= lvl) : (p < lvl && q >= lvl)) return k;
      if (am && k - PT == AT - 1) begin
        forced = 1;
        return k;
      end
    end
    return -1;
  endfunction

  // Frame = the last DEPTH decimated samples, PT of them before the trigger sample.
  task automatic plan(input int dec, input int lvl, input bit fall, input bit am, input int abort_cyc);
    int t, forced, nw;
    t = find_t(dec, lvl, fall, am, forced);
    nw = t >= 0 ? t + POSTN : LEN;
    for (int k = 0; k < nw; k++) begin
      if ((abort_cyc >= 0 && wcyc(dec, k) > abort_cyc) || samp(dec, k) < 0) begin
        nw = k;
        break;
      end
      wq.push_back('{(m_addr + k) % DEPTH, samp(dec, k), t0 + wcyc(dec, k)});
    end
    if (t >= 0 && nw == t + POSTN && (abort_cyc < 0 || abort_cyc > wcyc(dec, nw - 1)))
      fq.push_back('{(m_addr + t - PT + DEPTH) % DEPTH, forced});
    m_addr = (m_addr + nw) % DEPTH;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    adc_din = 8'(stream[cyc < LEN ? cyc : LEN - 1]);
    cyc++;
  endtask

  task automatic begin_cap(input int dec, input int lvl, input bit fall, input bit am);
    decim = 8'(dec);
    trig_level = 8'(lvl);
    trig_edge = fall;
    auto_mode = am;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    cyc = 0;
    t0 = tick;
    chk("busy_after_start", busy, 1);
    step_zero();
  endtask

  task automatic step_zero();
    adc_din = 8'(stream[0]);
    cyc = 1;
  endtask

  task automatic wait_frame();
    for (int i = 0; i < 3000 && !frame_valid; i++) step();
    chk("frame_valid_reached", frame_valid, 1);
  endtask

  task automatic ack(input bit cont);
    cont_mode = cont;
    frame_ack = 1;
    @(posedge clk);
    #1;
    frame_ack = 0;
    chk("fv_low_after_ack", frame_valid, 0);
    chk("busy_after_ack", busy, cont);
    t0 = tick;
    step_zero();
  endtask

  task automatic rand_stream();
    for (int j = 0; j < LEN; j++) stream[j] = $urandom_range(0, 255);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) step();
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int t, fc, a, lvl, dec;
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_frame_base", frame_base, 0);
    chk("rst_trig_forced", trig_forced, 0);
    chk("rst_busy", busy, 0);
    #20;
    @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk);
    #1;
    for (int j = 0; j < LEN; j++) stream[j] = j % 256;
    begin_cap(0, 128, 0, 0);
    plan(0, 128, 0, 0, -1);
    wait_frame();
    ack(0);
    rand_stream();
    lvl = $urandom_range(40, 215);
    begin_cap(3, lvl, 0, 1);
    plan(3, lvl, 0, 1, -1);
    wait_frame();
    ack(0);
    for (int j = 0; j < LEN; j++) stream[j] = 100;
    begin_cap(0, 128, 0, 1);
    plan(0, 128, 0, 1, -1);
    wait_frame();
    ack(0);
    begin_cap(1, 128, 0, 0);
    plan(1, 128, 0, 0, 300);
    while (cyc - 1 < 150) step();
    start = 1;
    step();
    start = 0;
    while (cyc - 1 < 300) step();
    chk("no_auto_busy", busy, 1);
    chk("no_auto_fv", frame_valid, 0);
    abort = 1;
    step();
    abort = 0;
    chk("abort_busy", busy, 0);
    idle_check(12);
    for (int j = 0; j < LEN; j++) stream[j] = j < 30 ? 50 : (j < 40 ? 200 : 50);
    begin_cap(0, 128, 1, 0);
    plan(0, 128, 1, 0, -1);
    wait_frame();
    ack(0);
    for (int n = 0; n < 3; n++) begin
      if (n == 0) begin
        rand_stream();
        dec = $urandom_range(0, 2);
        lvl = $urandom_range(40, 215);
        begin_cap(dec, lvl, n[0], 1);
      end
      plan(dec, lvl, n[0], 1, -1);
      wait_frame();
      rand_stream();
      dec = $urandom_range(0, 2);
      lvl = $urandom_range(40, 215);
      decim = 8'(dec);
      trig_level = 8'(lvl);
      trig_edge = ~n[0];
      ack(n != 2);
    end
    idle_check(10);
    rand_stream();
    lvl = $urandom_range(40, 215);
    t = find_t(1, lvl, 0, 1, fc);
    a = wcyc(1, t) + 6;
    begin_cap(1, lvl, 0, 1);
    plan(1, lvl, 0, 1, a);
    while (cyc - 1 < a) step();
    abort = 1;
    step();
    abort = 0;
    chk("abort_post_busy", busy, 0);
    chk("abort_post_fv", frame_valid, 0);
    idle_check(12);
    start = 1;
    abort = 1;
    step();
    start = 0;
    abort = 0;
    chk("start_abort_busy", busy, 0);
    idle_check(10);
    for (int j = 0; j < LEN; j++) stream[j] = 100;
    begin_cap(0, 128, 0, 0);
    plan(0, 128, 0, 0, PT + 9);
    while (cyc - 1 < PT + 10) step();
    #2;
    rst = 1;
    #1;
    chk("arst_wr_en", wr_en, 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_frame_valid", frame_valid, 0);
    chk("arst_frame_base", frame_base, 0);
    chk("arst_trig_forced", trig_forced, 0);
    chk("arst_busy", busy, 0);
    wq.delete();
    fq.delete();
    m_addr = 0;
    @(posedge clk);
    #1;
    rst = 0;
    step();
    for (int j = 0; j < LEN; j++) stream[j] = (j * 3) % 256;
    begin_cap(0, 90, 0, 0);
    plan(0, 90, 0, 0, -1);
    wait_frame();
    ack(0);
    idle_check(5);
    chk("queue_drained", wq.size() + fq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
